// File: rtl/alu_issue_if.sv
// Request/response channel bundle between a stimulus source and the alu_issue sequencer.
// master = source/consumer side, slave = alu_issue.
interface alu_issue_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic [3:0]      req_op;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_s;
    logic [3:0]      rsp_flags;
    logic            rsp_err;
    logic [15:0]     err_count;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_s, rsp_flags, rsp_err, err_count
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_s, rsp_flags, rsp_err, err_count
    );
endinterface

// File: rtl/alu_issue.sv
// One-at-a-time issue sequencer for a pipelined ALU: drives operands, waits the
// pipeline latency, captures result/flags/error and returns them on a handshake.
//
// state | meaning
// IDLE  | ready for a request; ALU pins hold the last operation
// WAIT  | operation in the ALU pipeline; cnt counts down to the capture edge
// RESP  | captured response presented until rsp_ready
module alu_issue #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_issue_if.slave      bus,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_s,
    input  logic            alu_n,
    input  logic            alu_z,
    input  logic            alu_v,
    input  logic            alu_c,
    input  logic            alu_hata
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] LAT = 2'(LATENCY);

    state_t          state_q;
    logic [1:0]      cnt_q;
    logic [XLEN-1:0] alu_a_q;
    logic [XLEN-1:0] alu_b_q;
    logic [3:0]      alu_op_q;
    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_s_q;
    logic [3:0]      rsp_flags_q;
    logic            rsp_err_q;
    logic [15:0]     err_count_q;
    logic [15:0]     err_count_d;
    logic            capture;

    assign capture = (state_q == S_WAIT) && (cnt_q == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= 4'b0000;
            rsp_valid_q <= 1'b0;
            rsp_s_q     <= '0;
            rsp_flags_q <= 4'b0000;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        alu_a_q  <= bus.req_a;
                        alu_b_q  <= bus.req_b;
                        alu_op_q <= bus.req_op;
                        cnt_q    <= LAT;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 2'd0) begin
                        rsp_s_q     <= alu_s;
                        rsp_flags_q <= {alu_n, alu_z, alu_v, alu_c};
                        rsp_err_q   <= alu_hata;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    // Saturates at all-ones rather than wrapping back to zero.
    always_comb begin
        err_count_d = err_count_q;
        if (capture && alu_hata && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= 16'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_s     = rsp_s_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.err_count = err_count_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_op        = alu_op_q;
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: two instances (LATENCY=2 and LATENCY=0), each driving a
// behavioural pipelined ALU; responses and timing checked against a reference model.
module tb_alu_issue;
    localparam int XLEN = 32;
    localparam int LAT0 = 2;
    localparam int LAT1 = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    alu_issue_if #(.XLEN(XLEN)) bus0 ();
    alu_issue_if #(.XLEN(XLEN)) bus1 ();

    logic [31:0] alu_a0, alu_b0, alu_a1, alu_b1;
    logic [3:0]  alu_op0, alu_op1;
    logic [36:0] res0, res1;

    // Reference ALU: {hata, n, z, v, c, s}
    function automatic logic [36:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        logic [32:0] w;
        logic [31:0] s;
        logic        v, c, h;
        w = '0; s = '0; v = 1'b0; c = 1'b0; h = 1'b0;
        case (op)
            4'b0000: begin
                w = {1'b0, a} + {1'b0, b};
                s = w[31:0]; c = w[32];
                v = (a[31] == b[31]) && (s[31] != a[31]);
            end
            4'b1000: begin
                w = {1'b0, a} + {1'b0, ~b} + 33'd1;
                s = w[31:0]; c = w[32];
                v = (a[31] != b[31]) && (s[31] != a[31]);
            end
            4'b0111: s = a & b;
            4'b0110: s = a | b;
            4'b0100: s = a ^ b;
            4'b0001: s = a << b[4:0];
            4'b0101: s = a >> b[4:0];
            4'b1101: s = $unsigned($signed(a) >>> b[4:0]);
            default: begin s = '0; h = 1'b1; end
        endcase
        return {h, s[31], (s == 32'd0), v, c, s};
    endfunction

    // ALU pipeline models: LAT0 register stages for inst0, purely combinational for inst1.
    logic [36:0] pipe0 [0:3];
    always @(posedge clk) begin
        pipe0[0] <= alu_f(alu_a0, alu_b0, alu_op0);
        for (int k = 1; k < 4; k++) pipe0[k] <= pipe0[k-1];
    end
    assign res0 = pipe0[LAT0-1];
    assign res1 = alu_f(alu_a1, alu_b1, alu_op1);

    alu_issue #(.XLEN(XLEN), .LATENCY(LAT0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_op(alu_op0),
        .alu_s(res0[31:0]), .alu_n(res0[35]), .alu_z(res0[34]), .alu_v(res0[33]),
        .alu_c(res0[32]), .alu_hata(res0[36])
    );

    alu_issue #(.XLEN(XLEN), .LATENCY(LAT1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1),
        .alu_s(res1[31:0]), .alu_n(res1[35]), .alu_z(res1[34]), .alu_v(res1[33]),
        .alu_c(res1[32]), .alu_hata(res1[36])
    );

    logic        o_rdy [2];
    logic        o_vld [2];
    logic [31:0] o_s   [2];
    logic [3:0]  o_fl  [2];
    logic        o_err [2];
    logic [15:0] o_ec  [2];
    logic [31:0] o_a   [2];
    logic [31:0] o_b   [2];
    logic [3:0]  o_op  [2];

    always_comb begin
        o_rdy[0] = bus0.req_ready; o_rdy[1] = bus1.req_ready;
        o_vld[0] = bus0.rsp_valid; o_vld[1] = bus1.rsp_valid;
        o_s[0]   = bus0.rsp_s;     o_s[1]   = bus1.rsp_s;
        o_fl[0]  = bus0.rsp_flags; o_fl[1]  = bus1.rsp_flags;
        o_err[0] = bus0.rsp_err;   o_err[1] = bus1.rsp_err;
        o_ec[0]  = bus0.err_count; o_ec[1]  = bus1.err_count;
        o_a[0]   = alu_a0;         o_a[1]   = alu_a1;
        o_b[0]   = alu_b0;         o_b[1]   = alu_b1;
        o_op[0]  = alu_op0;        o_op[1]  = alu_op1;
    end

    logic [15:0] ecnt_m [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op);
        if (i == 0) begin
            bus0.req_valid = v; bus0.req_a = a; bus0.req_b = b; bus0.req_op = op;
        end else begin
            bus1.req_valid = v; bus1.req_a = a; bus1.req_b = b; bus1.req_op = op;
        end
    endtask

    task automatic set_rdy(input int i, input logic r);
        if (i == 0) bus0.rsp_ready = r;
        else        bus1.rsp_ready = r;
    endtask

    task automatic chk_zero(input int i);
        chk("rst_alu_a", 64'(o_a[i]), 64'd0);
        chk("rst_alu_b", 64'(o_b[i]), 64'd0);
        chk("rst_alu_op", 64'(o_op[i]), 64'd0);
        chk("rst_rsp_s", 64'(o_s[i]), 64'd0);
        chk("rst_flags", 64'(o_fl[i]), 64'd0);
        chk("rst_err", 64'(o_err[i]), 64'd0);
        chk("rst_valid", 64'(o_vld[i]), 64'd0);
        chk("rst_ecnt", 64'(o_ec[i]), 64'd0);
    endtask

    // Issue one op, hold rsp_ready low for 'hold' cycles after rsp_valid rises.
    task automatic do_op(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input int hold, output logic [36:0] got);
        logic [36:0] exp;
        int lat, n;
        lat = (i == 0) ? LAT0 : LAT1;
        exp = alu_f(a, b, op);
        if (exp[36] && ecnt_m[i] != 16'hFFFF) ecnt_m[i] = ecnt_m[i] + 16'd1;
        @(negedge clk);
        drive(i, 1'b1, a, b, op);
        set_rdy(i, hold == 0);
        chk("req_ready_idle", 64'(o_rdy[i]), 64'd1);
        @(posedge clk); #1;
        drive(i, 1'b0, '0, '0, '0);
        chk("alu_a", 64'(o_a[i]), 64'(a));
        chk("alu_b", 64'(o_b[i]), 64'(b));
        chk("alu_op", 64'(o_op[i]), 64'(op));
        n = 0;
        while (!o_vld[i] && n < 10) begin
            chk("req_ready_wait", 64'(o_rdy[i]), 64'd0);
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(lat + 1));
        got = {o_err[i], o_fl[i], o_s[i]};
        chk("rsp", 64'(got), 64'(exp));
        chk("err_count", 64'(o_ec[i]), 64'(ecnt_m[i]));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("bp_valid", 64'(o_vld[i]), 64'd1);
            chk("bp_ready", 64'(o_rdy[i]), 64'd0);
            chk("bp_rsp", 64'({o_err[i], o_fl[i], o_s[i]}), 64'(exp));
            chk("bp_alu", 64'({o_op[i], o_a[i], o_b[i]}), 64'({op, a, b}));
        end
        @(negedge clk);
        set_rdy(i, 1'b1);
        @(posedge clk); #1;
        chk("rsp_done", 64'(o_vld[i]), 64'd0);
        chk("back_idle", 64'(o_rdy[i]), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [36:0] got;
        ecnt_m[0] = 16'd0; ecnt_m[1] = 16'd0;
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        set_rdy(0, 1'b1); set_rdy(1, 1'b1);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk_zero(0);
        chk_zero(1);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("ready_after_rst0", 64'(o_rdy[0]), 64'd1);
        chk("ready_after_rst1", 64'(o_rdy[1]), 64'd1);

        // Directed points on the LATENCY=2 instance
        do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0000, 0, got);
        chk("add_s", 64'(got[31:0]), 64'h8000_0000);
        chk("add_flags", 64'(got[35:32]), 64'b1010);
        chk("add_err", 64'(got[36]), 64'd0);
        do_op(0, 32'd5, 32'd5, 4'b1000, 0, got);
        chk("sub_s", 64'(got[31:0]), 64'd0);
        chk("sub_flags", 64'(got[35:32]), 64'b0101);
        do_op(0, 32'h8000_0000, 32'd4, 4'b1101, 0, got);
        chk("sra_s", 64'(got[31:0]), 64'hF800_0000);
        chk("sra_n", 64'(got[35]), 64'd1);
        chk("sra_c", 64'(got[32]), 64'd0);
        do_op(0, 32'h1234_5678, 32'h9ABC_DEF0, 4'b1111, 0, got);
        chk("ill_s", 64'(got[31:0]), 64'd0);
        chk("ill_err", 64'(got[36]), 64'd1);
        chk("ill_ecnt", 64'(o_ec[0]), 64'd1);
        do_op(0, 32'hDEAD_BEEF, 32'h0000_0101, 4'b0000, 5, got);

        // Randomised traffic with random backpressure
        for (int r = 0; r < 24; r++) begin
            do_op(0, $urandom, ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 31)) : $urandom,
                  4'($urandom_range(0, 15)), $urandom_range(0, 3), got);
        end

        // Saturation: preload the counter, then another illegal op must not wrap
        @(negedge clk);
        force dut0.err_count_q = 16'hFFFF;
        @(negedge clk);
        release dut0.err_count_q;
        ecnt_m[0] = 16'hFFFF;
        #1 chk("sat_preload", 64'(o_ec[0]), 64'hFFFF);
        do_op(0, 32'd1, 32'd2, 4'b1110, 0, got);
        chk("sat_hold", 64'(o_ec[0]), 64'hFFFF);

        // Reset in the middle of WAIT discards the operation
        @(negedge clk);
        drive(0, 1'b1, 32'hAAAA_5555, 32'h0F0F_0F0F, 4'b1011);
        @(posedge clk); #1;
        drive(0, 1'b0, '0, '0, '0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_zero(0);
        ecnt_m[0] = 16'd0; ecnt_m[1] = 16'd0;
        @(negedge clk) rst_n = 1'b1;
        #1 chk("ready_after_mid_rst", 64'(o_rdy[0]), 64'd1);
        for (int k = 0; k < LAT0 + 4; k++) begin
            @(posedge clk); #1;
            chk("no_rsp_after_rst", 64'(o_vld[0]), 64'd0);
        end
        do_op(0, 32'd100, 32'd23, 4'b1000, 1, got);
        chk("post_rst_s", 64'(got[31:0]), 64'd77);

        // LATENCY=0 instance
        do_op(1, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0000, 0, got);
        chk("l0_add_s", 64'(got[31:0]), 64'h8000_0000);
        chk("l0_add_flags", 64'(got[35:32]), 64'b1010);
        do_op(1, 32'h0, 32'h0, 4'b1001, 2, got);
        chk("l0_ill_ecnt", 64'(o_ec[1]), 64'd1);
        for (int r = 0; r < 12; r++) begin
            do_op(1, $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
# alu_issue

Request-side sequencer for the `alu2020`-style ALU. It accepts one operation at a time over a valid/ready request channel and drives the ALU operand and op pins. It waits the configured ALU pipeline latency, captures the result, flags and error bit, and returns them over a valid/ready response channel. It also keeps a saturating count of illegal-op responses. It sits between an instruction or test-stimulus source and the ALU instance.

## Interface
Parameters:
- XLEN, 32, operand/result width; must match the ALU instance.
- LATENCY, 2, number of ALU register stages (ALU INPUT_REG + OUTPUT_REG); legal range 0..3.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_a, req_b  in  XLEN  operands.
- req_op  in  4  ALU opcode, passed through unchecked.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_s  out  XLEN  captured result.
- rsp_flags  out  4  captured {n, z, v, c}.
- rsp_err  out  1  captured ALU error (illegal op).
- err_count  out  16  saturating count of responses with rsp_err=1.
- alu_a, alu_b  out  XLEN  ALU operand pins.
- alu_op  out  4  ALU op pin.
- alu_s  in  XLEN  ALU result.
- alu_n, alu_z, alu_v, alu_c  in  1 each  ALU flags.
- alu_hata  in  1  ALU error.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - req_ready=1, rsp_valid=0.
  - On req_valid: register req_a/req_b/req_op into alu_a/alu_b/alu_op, load cnt=LATENCY, and go to WAIT.
- WAIT:
  - req_ready=0, rsp_valid=0.
  - If cnt==0: capture alu_s into rsp_s and {alu_n,alu_z,alu_v,alu_c} into rsp_flags, capture alu_hata into rsp_err, and go to RESP.
  - Otherwise decrement cnt.
- RESP:
  - rsp_valid=1, req_ready=0.
  - On rsp_ready: go to IDLE.
  - The response registers hold stable while rsp_valid=1 and rsp_ready=0.
- alu_a/alu_b/alu_op change only on request accept and otherwise hold their last value. They stay stable for the whole ALU latency.
- err_count increments by 1 on the capture edge when alu_hata=1. It saturates at 0xFFFF with no wrap.
- The block does not decode or check opcodes. Illegal-op detection comes solely from alu_hata.
- cnt is 2 bits wide.
- Reset (asynchronous, any state including WAIT/RESP mid-operation):
  - State goes to IDLE.
  - All outputs go to 0: alu_a, alu_b, alu_op=4'b0000 (ADD, so the ALU reports no error), rsp_s, rsp_flags, rsp_err, rsp_valid, err_count.
  - req_ready=1 once reset is released.
  - The in-flight operation is discarded; no response is produced for it.

## Timing
- Accept on edge E0 (req_valid & req_ready). alu_* pins are valid after E0.
- Capture on edge E0+LATENCY+1, which covers all ALU register stages plus one cycle of settling margin.
- rsp_valid is high from after E0+LATENCY+1 until the edge where rsp_ready=1.
- With rsp_ready tied high:
  - response handshake on E0+LATENCY+2;
  - next accept on E0+LATENCY+3 at the earliest;
  - throughput is one op per LATENCY+3 cycles.
- req_ready is combinationally equal to (state==IDLE) and does not depend on req_valid.
- rsp_valid=1 does not depend on rsp_ready.
- Simultaneous request and response handshakes cannot occur, because req_ready=0 in RESP.

## Test plan
- LATENCY=2, ADD: a=0x7FFFFFFF, b=0x00000001, op=4'b0000, accepted at E0.
  - rsp_valid rises after E3.
  - rsp_s=0x80000000, flags {n,z,v,c}=4'b1010, rsp_err=0.
- SUB equal operands: a=b=0x00000005, op=4'b1000 → rsp_s=0, flags=4'b0101.
- SRA: a=0x80000000, b=0x00000004, op=4'b1101 → rsp_s=0xF8000000, n=1, c=0.
- Illegal op and counter saturation:
  - op=4'b1111 → rsp_s=0, rsp_err=1, err_count goes 0→1.
  - Preload err_count to 0xFFFF, issue another illegal op → err_count stays 0xFFFF.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid rises.
  - rsp_s/rsp_flags/rsp_err stay constant.
  - req_ready=0 throughout.
  - alu_* unchanged.
  - Raise rsp_ready → IDLE on the next edge.
- Reset and latency corner cases:
  - Assert rst_n=0 mid-WAIT → all outputs 0 immediately, no response after release, and the next request completes normally.
  - LATENCY=0 build → capture on E1 and rsp_valid after E1.
